// File: rtl/pad_bus_arbiter.sv
// pad_bus_arbiter: round-robin sharing of the serialized pad bus between the CPU (port 0) and DMA/debug (port 1).
// Optional feature ADDR_CACHE_EN: skip the address-high byte when it repeats the last one sent.
//
// state | meaning
// IDLE  | no owner; samples req (held off while an err pulse is out)
// AH    | address high byte on pads, lh=10
// AL    | address low byte on pads, lh=01
// DATA  | write byte (lh=11) or read slot (lh=00, din captured)
// DONE  | ack pulse to owner, owner released
module pad_bus_arbiter #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_i,
   input  logic [1:0]          we_i,
   input  logic [2*DATA_W-1:0] addr0_i,
   input  logic [2*DATA_W-1:0] addr1_i,
   input  logic [DATA_W-1:0]   wdata0_i,
   input  logic [DATA_W-1:0]   wdata1_i,
   output logic [1:0]          ack_o,
   output logic [1:0]          err_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic [1:0]          gnt_o,
   output logic [DATA_W-1:0]   dout_pad_o,
   output logic [1:0]          lh_o,
   input  logic [DATA_W-1:0]   din_pad_i,
   input  logic                pad_rdy_i
);

   localparam int AW = 2*DATA_W;
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_AH, S_AL, S_DATA, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        err_q, err_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [WD_W-1:0]   wd_q, wd_d;

   logic              win;
   logic              own;
   logic              own_we;
   logic [AW-1:0]     own_addr;
   logic [DATA_W-1:0] own_wdata;

   // Contention goes to the port after the last owner.
   assign win       = (&req_i) ? ~last_q : req_i[1];
   assign own       = gnt_q[1];
   assign own_we    = own ? we_i[1] : we_i[0];
   assign own_addr  = own ? addr1_i : addr0_i;
   assign own_wdata = own ? wdata1_i : wdata0_i;

`ifdef ADDR_CACHE_EN
   logic [DATA_W-1:0] cache_q, cache_d;
   logic              cache_vld_q, cache_vld_d;
   logic [AW-1:0]     win_addr;
   logic              cache_hit;

   assign win_addr  = win ? addr1_i : addr0_i;
   assign cache_hit = cache_vld_q && (win_addr[AW-1:DATA_W] == cache_q);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         gnt_q       <= 2'b00;
         err_q       <= 2'b00;
         last_q      <= 1'b1;
         rdata_q     <= '0;
         wd_q        <= '0;
`ifdef ADDR_CACHE_EN
         cache_q     <= '0;
         cache_vld_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         err_q       <= err_d;
         last_q      <= last_d;
         rdata_q     <= rdata_d;
         wd_q        <= wd_d;
`ifdef ADDR_CACHE_EN
         cache_q     <= cache_d;
         cache_vld_q <= cache_vld_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      err_d   = 2'b00;
      last_d  = last_q;
      rdata_d = rdata_q;
      wd_d    = wd_q;
`ifdef ADDR_CACHE_EN
      cache_d     = cache_q;
      cache_vld_d = cache_vld_q;
`endif
      case (state_q)
         S_IDLE: begin
            // The aborted owner still holds req during its err cycle.
            if ((|req_i) && (err_q == 2'b00)) begin
               gnt_d   = win ? 2'b10 : 2'b01;
               wd_d    = WD_LOAD;
               state_d = S_AH;
`ifdef ADDR_CACHE_EN
               if (cache_hit) state_d = S_AL;
`endif
            end
         end
         S_AH, S_AL, S_DATA: begin
            if (pad_rdy_i) begin
               wd_d = WD_LOAD;
               if (state_q == S_AH) begin
                  state_d = S_AL;
`ifdef ADDR_CACHE_EN
                  cache_d     = own_addr[AW-1:DATA_W];
                  cache_vld_d = 1'b1;
`endif
               end else if (state_q == S_AL) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_DONE;
                  if (!own_we) rdata_d = din_pad_i;
               end
            end else if ((TIMEOUT != 0) && (wd_q == WD_ONE)) begin
               state_d = S_IDLE;
               err_d   = gnt_q;
               gnt_d   = 2'b00;
               last_d  = own;
               wd_d    = '0;
`ifdef ADDR_CACHE_EN
               cache_vld_d = 1'b0;
`endif
            end else begin
               wd_d = wd_q - WD_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
            last_d  = own;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dout_pad_o = '0;
      lh_o       = 2'b00;
      ack_o      = 2'b00;
      case (state_q)
         S_AH: begin
            dout_pad_o = own_addr[AW-1:DATA_W];
            lh_o       = 2'b10;
         end
         S_AL: begin
            dout_pad_o = own_addr[DATA_W-1:0];
            lh_o       = 2'b01;
         end
         S_DATA: begin
            if (own_we) begin
               dout_pad_o = own_wdata;
               lh_o       = 2'b11;
            end
         end
         S_DONE: ack_o = gnt_q;
         default: ;
      endcase
   end

   assign err_o   = err_q;
   assign gnt_o   = gnt_q;
   assign rdata_o = rdata_q;

endmodule
